// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1:4 valid/ready stream demultiplexer.
package stream_demux_pkg;

    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] dst_t;

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side and consumer-side handshake bundle of the 1:4 stream demux.
interface stream_demux_if #(parameter int W = 4);
    import stream_demux_pkg::*;

    logic               in_valid;
    logic               in_ready;
    dst_t               in_sel;
    logic [W-1:0]       in_data;
    logic [N_OUT-1:0]   out_valid;
    logic [N_OUT-1:0]   out_ready;
    logic [N_OUT*W-1:0] out_data;

    // master: producer plus consumers around the demux; slave: the demux itself.
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/stream_demux_1_2.sv
// One registered 1:2 demux stage; the XW select bits still needed downstream ride in the data word.
module stream_demux_1_2 #(
    parameter int W  = 4,
    parameter int XW = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    output logic            up_ready,
    input  logic            up_dst,
    input  logic [W+XW-1:0] up_data,
    output logic [1:0]      down_valid,
    input  logic [1:0]      down_ready,
    output logic [W+XW-1:0] down_data
);

    localparam int DW = W + XW;

    logic          valid_q, valid_d;
    logic          dst_q, dst_d;
    logic [DW-1:0] data_q, data_d;
    logic          load;
    logic          drain;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d  = valid_q;
        dst_d    = dst_q;
        data_d   = data_q;
        drain    = valid_q && down_ready[dst_q];
        up_ready = !valid_q || down_ready[dst_q];
        load     = up_valid && up_ready;
        if (load) begin
            // A load in the same cycle as a drain simply overwrites the leaving word.
            valid_d = 1'b1;
            dst_d   = up_dst;
            data_d  = up_data;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dst_q   <= 1'b0;
            // NOTE: the payload register is reset too, because out_data must read zero after reset.
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
        end
    end

    assign down_valid = {valid_q && dst_q, valid_q && !dst_q};
    assign down_data  = data_q;

endmodule

// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready demux: a level-1 stage steered by sel[1] feeding two level-2 stages steered by sel[0].
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    stream_demux_if.slave  bus
);

    logic [1:0]   l1_valid;
    logic         l1_ready_lo, l1_ready_hi;
    logic [W:0]   l1_data;
    logic [1:0]   lo_valid, hi_valid;
    logic [W-1:0] lo_data, hi_data;

    stream_demux_1_2 #(.W(W), .XW(1)) u_l1 (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (bus.in_valid),
        .up_ready   (bus.in_ready),
        .up_dst     (bus.in_sel[1]),
        .up_data    ({bus.in_sel[0], bus.in_data}),
        .down_valid (l1_valid),
        .down_ready ({l1_ready_hi, l1_ready_lo}),
        .down_data  (l1_data)
    );

    stream_demux_1_2 #(.W(W), .XW(0)) u_l2_lo (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (l1_valid[0]),
        .up_ready   (l1_ready_lo),
        .up_dst     (l1_data[W]),
        .up_data    (l1_data[W-1:0]),
        .down_valid (lo_valid),
        .down_ready (bus.out_ready[1:0]),
        .down_data  (lo_data)
    );

    stream_demux_1_2 #(.W(W), .XW(0)) u_l2_hi (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (l1_valid[1]),
        .up_ready   (l1_ready_hi),
        .up_dst     (l1_data[W]),
        .up_data    (l1_data[W-1:0]),
        .down_valid (hi_valid),
        .down_ready (bus.out_ready[N_OUT-1:2]),
        .down_data  (hi_data)
    );

    // Both outputs of a branch share that branch's payload register.
    assign bus.out_valid = {hi_valid, lo_valid};
    assign bus.out_data  = {hi_data, hi_data, lo_data, lo_data};

endmodule
